topmodule_cmd_sequencer: RTL and testbench
==========================================

// Module: topmodule_cmd_sequencer
// PURPOSE
//  Upstream command stage for rtl_topmodule: queues (A,C) commands, drives dut_a/dut_c,
//  waits a fixed settle time, samples the 11-bit result, returns it via valid/ready.
//  Replaces bench-driven A/C stimulus in the integrated flow; function selection is by C
//  (C in 100..128 selects the parity generator, result bit 0).
// PARAMETERS
//  DEPTH   4   command FIFO entries (power of 2, >=2)
//  SETTLE  2   cycles from dut_a/dut_c update to result sample (>=1)
//  A_W     10  width of A operand
//  C_W     9   width of C selector
//  OUT_W   11  width of rtl_topmodule result
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      FIFO not full
//  cmd_a      in   A_W    operand A
//  cmd_c      in   C_W    selector C
//  dut_a      out  A_W    registered A to rtl_topmodule
//  dut_c      out  C_W    registered C to rtl_topmodule
//  dut_out    in   OUT_W  result from rtl_topmodule
//  res_valid  out  1      result held
//  res_ready  in   1      consumer accepts
//  res_data   out  OUT_W  captured result
//  res_c      out  C_W    C of the command that produced res_data
//  res_err    out  1      parity-check mismatch (see CONFIGURATION)
//  busy       out  1      FSM not IDLE or FIFO not empty
// BEHAVIOUR
//  Reset (rst=0, async): FIFO pointers/count 0, FSM IDLE, all outputs 0 except cmd_ready=1.
//  Push on cmd_valid&&cmd_ready. cmd_ready = !full, registered-state only; no comb path from res_ready.
//  Full FIFO: cmd_ready=0, cmd_valid ignored. Push and pop in same cycle: count unchanged.
//  Pointers wrap modulo DEPTH; count in $clog2(DEPTH)+1 bits.
//  FSM IDLE/WAIT/RESP:
//   IDLE: FIFO non-empty -> pop, load dut_a/dut_c, cnt=SETTLE-1, -> WAIT. Empty -> stay.
//   WAIT: cnt>0 -> cnt--. cnt==0 -> res_data<=dut_out, res_c<=dut_c, res_valid<=1, -> RESP.
//   RESP: hold res_* stable until res_valid&&res_ready. On handshake: FIFO non-empty ->
//         pop+load+cnt=SETTLE-1, -> WAIT (back-to-back); else res_valid<=0, -> IDLE.
//  Latency: push at edge E0 -> dut_a/dut_c update at E1 -> capture at E1+SETTLE
//   (res_valid high SETTLE+1 cycles after accept). Steady-state throughput 1 result per
//   SETTLE+1 cycles with res_ready=1.
//  dut_a/dut_c hold last command between commands (no return to 0).
//  Results in strict command order; none dropped or duplicated.
//  Reset mid-operation: in-flight and queued commands discarded, res_valid drops immediately.
// CONFIGURATION
//  PARITY_CHECK_EN defined: at capture, if 100<=dut_c<=128, res_err<=(dut_out[0] != ^dut_a);
//   else res_err<=0. Held with res_data.
//  Undefined: res_err tied 0, no checker logic.
// STRUCTURE
//  topmodule_pkg: A_W/C_W/OUT_W defaults, PARITY_C_LO=100, PARITY_C_HI=128, FSM state enum.
//  Sub-module cmd_fifo (DEPTH x (A_W+C_W), sync push/pop, full/empty, async active-low reset).
//  FSM, settle counter, result registers, optional checker live in this module.
// TESTING (bench instantiates real rtl_topmodule on dut_a/dut_c/dut_out)
//  1 Reset: rst=0 mid-run -> res_valid=0, dut_a=0, dut_c=0, cmd_ready=1, busy=0 same cycle.
//  2 Single: C=110 A=10'b0000000001, res_ready=1 -> res_valid 3 cycles after accept
//    (SETTLE=2), res_data[0]=1, res_c=110.
//  3 Order: C=110, A=0000000011/1111111111/1111111110 back-to-back ->
//    res_data[0]=0,0,1 in order, 3 cycles apart.
//  4 Backpressure: res_ready=0, push 6 commands -> 5 accepted (1 in flight + 4 queued),
//    cmd_ready=0; release -> 5 results in order.
//  5 Reset in WAIT: rst=0 one cycle after accept -> no res_valid ever for that command;
//    FIFO empty after.
//  6 PARITY_CHECK_EN: stub DUT inverting out[0], C=110 -> res_err=1; C=50 -> res_err=0;
//    macro off -> res_err=0 always.

Source files
------------

// File: rtl/topmodule_pkg.sv
// Shared widths, parity-select window and sequencer state encoding.
// No logic of its own; imported by the command sequencer and its FIFO users.
// Parity window is inclusive on both ends.
package topmodule_pkg;

  localparam int A_W   = 10;
  localparam int C_W   = 9;
  localparam int OUT_W = 11;

  localparam logic [C_W-1:0] PARITY_C_LO = C_W'(100);
  localparam logic [C_W-1:0] PARITY_C_HI = C_W'(128);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the selector routes rtl_topmodule to its parity generator.
  function automatic logic parity_sel(input logic [C_W-1:0] c);
    return (c >= PARITY_C_LO) && (c <= PARITY_C_HI);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries of W bits, show-ahead read data at the head.
// Latency: a push is visible on pop_dat_o / empty_o the cycle after it is written.
// Backpressure: full_o is a registered-state decode; pushes while full and pops while empty are ignored.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally (power-of-2 depth); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/topmodule_cmd_sequencer.sv
// Queues (A,C) commands, drives rtl_topmodule, samples its result SETTLE cycles later. Optional: PARITY_CHECK_EN.
// Latency: accept at E0 -> dut_a/dut_c at E1 -> result valid at E1+SETTLE; one result per SETTLE+1 cycles.
// Backpressure: cmd_ready = FIFO not full (registered); results held until res_ready, no comb path to cmd_ready.
module topmodule_cmd_sequencer
  import topmodule_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [A_W-1:0]   cmd_a,
  input  logic [C_W-1:0]   cmd_c,
  output logic [A_W-1:0]   dut_a,
  output logic [C_W-1:0]   dut_c,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic [C_W-1:0]   res_c,
  output logic             res_err,
  output logic             busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [A_W-1:0]     dut_a_q;
  logic [C_W-1:0]     dut_c_q;
  logic [OUT_W-1:0]   res_data_q;
  logic [C_W-1:0]     res_c_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [A_W+C_W-1:0] fifo_dat;
  logic [A_W-1:0]     fifo_a;
  logic [C_W-1:0]     fifo_c;
  logic               load;
  logic               capture;

  cmd_fifo #(
    .DEPTH(DEPTH),
    .W    (A_W + C_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (cmd_valid),
    .push_dat_i({cmd_a, cmd_c}),
    .pop_i     (load),
    .pop_dat_o (fifo_dat),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign {fifo_a, fifo_c} = fifo_dat;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: go straight from a result handshake to the next command when one is queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: if (res_ready)   state_d = fifo_empty ? ST_IDLE : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control strobes: pop+load a command, or capture the settled result.
  always_comb begin
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: load    = !fifo_empty;
      ST_WAIT: capture = (cnt_q == '0);
      ST_RESP: load    = res_ready && !fifo_empty;
      default: ;
    endcase
  end

  // Operand, settle counter and result registers; dut_a/dut_c hold between commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dut_a_q    <= '0;
      dut_c_q    <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_c_q    <= '0;
    end else begin
      if (load) begin
        dut_a_q <= fifo_a;
        dut_c_q <= fifo_c;
        cnt_q   <= CNT_W'(SETTLE - 1);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        res_data_q <= dut_out;
        res_c_q    <= dut_c_q;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic res_err_q;

  // Flag a parity-generator result whose bit 0 disagrees with the parity of A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_err_q <= 1'b0;
    end else if (capture) begin
      res_err_q <= parity_sel(dut_c_q) && (dut_out[0] != (^dut_a_q));
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  // res_valid is a pure state decode, so it drops the instant reset asserts.
  assign res_valid = (state_q == ST_RESP);
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign dut_a     = dut_a_q;
  assign dut_c     = dut_c_q;
  assign res_data  = res_data_q;
  assign res_c     = res_c_q;

endmodule

// File: tb/tb_topmodule_cmd_sequencer.sv
// Self-checking bench for topmodule_cmd_sequencer with a behavioural stand-in for rtl_topmodule.
// Expected results come from a queue-based reference model fed at command acceptance.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_topmodule_cmd_sequencer;
  import topmodule_pkg::*;

  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [C_W-1:0]   c;
    logic             err;
    logic [31:0]      cyc;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [A_W-1:0]   cmd_a = '0;
  logic [C_W-1:0]   cmd_c = '0;
  logic [A_W-1:0]   dut_a;
  logic [C_W-1:0]   dut_c;
  logic [OUT_W-1:0] dut_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [OUT_W-1:0] res_data;
  logic [C_W-1:0]   res_c;
  logic             res_err;
  logic             busy;
  logic             stub_inv = 1'b0;

  int   total = 0;
  int   bad   = 0;
  logic [31:0] cyc = '0;
  res_t exp_q[$];
  res_t obs_q[$];
  res_t mon_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Stand-in for rtl_topmodule: bit 0 is parity of A (optionally inverted), upper bits mix A and C.
  function automatic logic [OUT_W-1:0] stub_fn(input logic [A_W-1:0] a, input logic [C_W-1:0] c,
                                               input logic inv);
    logic [A_W-1:0] hi;
    hi = a ^ A_W'(c);
    return {hi, (^a) ^ inv};
  endfunction

  assign dut_out = stub_fn(dut_a, dut_c, stub_inv);

  function automatic res_t model(input logic [A_W-1:0] a, input logic [C_W-1:0] c, input logic inv);
    res_t r;
    r.data = stub_fn(a, c, inv);
    r.c    = c;
    r.err  = PAR_EN && (int'(c) >= 100) && (int'(c) <= 128) && (r.data[0] != (^a));
    r.cyc  = '0;
    return r;
  endfunction

  topmodule_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_c    (cmd_c),
    .dut_a    (dut_a),
    .dut_c    (dut_c),
    .dut_out  (dut_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_c    (res_c),
    .res_err  (res_err),
    .busy     (busy)
  );

  // Record accepted commands (as model predictions) and delivered results.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_c, stub_inv));
      if (res_valid && res_ready) begin
        mon_r.data = res_data;
        mon_r.c    = res_c;
        mon_r.err  = res_err;
        mon_r.cyc  = cyc;
        obs_q.push_back(mon_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [A_W-1:0] a, input logic [C_W-1:0] c, output bit ok);
    int k;
    cmd_a = a;
    cmd_c = c;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 300) begin
      tick();
      k++;
    end
    ok = cmd_ready;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({cmd_ready, res_valid, busy, res_err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: got rdy/vld/busy/err=%b want 1000", {cmd_ready, res_valid, busy, res_err});
    end
    total++;
    if ({dut_a, dut_c} !== '0) begin
      bad++;
      $display("FAIL reset_dut_ac: got a=%0h c=%0h want 0", dut_a, dut_c);
    end
    total++;
    if ({res_data, res_c} !== '0) begin
      bad++;
      $display("FAIL reset_res: got data=%0h c=%0h want 0", res_data, res_c);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int n;
    res_t e;
    stub_inv  = 1'b0;
    res_ready = 1'b1;
    e = model(10'b0000000001, 9'd110, 1'b0);
    send(10'b0000000001, 9'd110, ok);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n != SETTLE + 1) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles want %0d", n, SETTLE + 1);
    end
    total++;
    if (res_data[0] !== 1'b1 || res_data !== e.data) begin
      bad++;
      $display("FAIL single_data: got %0h want %0h", res_data, e.data);
    end
    total++;
    if (res_c !== 9'd110) begin
      bad++;
      $display("FAIL single_res_c: got %0d want 110", res_c);
    end
    repeat (4) tick();
    total++;
    if ({res_valid, busy} !== 2'b00 || dut_a !== 10'd1 || dut_c !== 9'd110) begin
      bad++;
      $display("FAIL single_hold: got vld/busy=%b a=%0h c=%0d want 00 a=1 c=110", {res_valid, busy}, dut_a, dut_c);
    end
    total++;
    if (obs_q.size() != 1) begin
      bad++;
      $display("FAIL single_count: got %0d results want 1", obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_order();
    bit ok;
    logic [A_W-1:0] as [3];
    logic [2:0] want_b0;
    as[0] = 10'b0000000011;
    as[1] = 10'b1111111111;
    as[2] = 10'b1111111110;
    want_b0 = 3'b100;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(as[i], 9'd110, ok);
    wait_results(3, ok);
    total++;
    if (!ok || exp_q.size() != 3) begin
      bad++;
      $display("FAIL order_count: got %0d results/%0d accepted want 3", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].c !== exp_q[i].c ||
          obs_q[i].data[0] !== want_b0[i]) begin
        bad++;
        $display("FAIL order[%0d]: got data=%0h c=%0d want data=%0h c=%0d", i,
                 obs_q[i].data, obs_q[i].c, exp_q[i].data, exp_q[i].c);
      end
      if (i > 0) begin
        total++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != 32'(SETTLE + 1)) begin
          bad++;
          $display("FAIL order_spacing[%0d]: got %0d want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, SETTLE + 1);
        end
      end
    end
    repeat (3) tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc;
    logic [A_W-1:0] as [6];
    logic [C_W-1:0] cs [6];
    for (int i = 0; i < 6; i++) begin
      as[i] = A_W'($urandom);
      cs[i] = C_W'($urandom);
    end
    res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      cmd_valid = 1'b1;
      cmd_a = as[acc];
      cmd_c = cs[acc];
      if (cmd_ready) acc++;
      tick();
      if (acc == 6) break;
    end
    cmd_valid = 1'b0;
    total++;
    if (acc != 5) begin
      bad++;
      $display("FAIL bp_accepted: got %0d want 5", acc);
    end
    total++;
    if ({cmd_ready, res_valid, busy} !== 3'b011) begin
      bad++;
      $display("FAIL bp_flags: got rdy/vld/busy=%b want 011", {cmd_ready, res_valid, busy});
    end
    res_ready = 1'b1;
    wait_results(5, ok);
    repeat (2) tick();
    total++;
    if (!ok || obs_q.size() != 5 || exp_q.size() != 5) begin
      bad++;
      $display("FAIL bp_count: got %0d results/%0d accepted want 5", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].c !== exp_q[i].c || obs_q[i].c !== cs[i]) begin
        bad++;
        $display("FAIL bp[%0d]: got data=%0h c=%0d want data=%0h c=%0d", i,
                 obs_q[i].data, obs_q[i].c, exp_q[i].data, cs[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity();
    bit ok;
    logic [C_W-1:0] cs [6];
    cs[0] = 9'd110; cs[1] = 9'd50;  cs[2] = 9'd100;
    cs[3] = 9'd128; cs[4] = 9'd129; cs[5] = 9'd99;
    stub_inv  = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(A_W'($urandom), cs[i], ok);
    wait_results(6, ok);
    repeat (2) tick();
    total++;
    if (!ok || obs_q.size() != 6) begin
      bad++;
      $display("FAIL parity_count: got %0d want 6", obs_q.size());
    end
    if (obs_q.size() >= 2) begin
      total++;
      if (obs_q[0].err !== PAR_EN || obs_q[1].err !== 1'b0) begin
        bad++;
        $display("FAIL parity_c110_c50: got err=%b%b want %b0", obs_q[0].err, obs_q[1].err, PAR_EN);
      end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err) begin
        bad++;
        $display("FAIL parity[%0d] c=%0d: got data=%0h err=%b want data=%0h err=%b", i, cs[i],
                 obs_q[i].data, obs_q[i].err, exp_q[i].data, exp_q[i].err);
      end
    end
    stub_inv = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    bit all_ok;
    bit done;
    int nmis;
    all_ok = 1'b1;
    done   = 1'b0;
    stub_inv = 1'($urandom);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [C_W-1:0] c;
          c = ($urandom % 2 == 0) ? C_W'($urandom_range(90, 135)) : C_W'($urandom);
          send(A_W'($urandom), c, ok);
          if (!ok) all_ok = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !done; k++) begin
          res_ready = ($urandom % 3 != 0);
          tick();
        end
      end
    join
    res_ready = 1'b1;
    wait_results(60, ok);
    repeat (2) tick();
    total++;
    if (!all_ok || !ok || obs_q.size() != 60 || exp_q.size() != 60) begin
      bad++;
      $display("FAIL rand_count: got %0d results/%0d accepted want 60", obs_q.size(), exp_q.size());
    end
    nmis = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].c !== exp_q[i].c || obs_q[i].err !== exp_q[i].err)
        nmis++;
    end
    total++;
    if (nmis != 0) begin
      bad++;
      $display("FAIL rand_stream: got %0d mismatched results want 0", nmis);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int n;
    int seen;
    res_ready = 1'b1;
    send(10'h155, 9'd110, ok);
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({res_valid, cmd_ready, busy} !== 3'b010 || dut_a !== '0 || dut_c !== '0) begin
      bad++;
      $display("FAIL rst_wait: got vld/rdy/busy=%b a=%0h c=%0h want 010 a=0 c=0",
               {res_valid, cmd_ready, busy}, dut_a, dut_c);
    end
    exp_q.delete();
    obs_q.delete();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (res_valid) seen++;
    end
    total++;
    if (seen != 0 || obs_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_after: got %0d valid cycles busy=%b want 0 busy=0", seen, busy);
    end
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(A_W'($urandom), C_W'($urandom), ok);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b0;
    #1;
    total++;
    if ({res_valid, cmd_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL rst_resp: got vld/rdy/busy=%b want 010 (waited %0d)", {res_valid, cmd_ready, busy}, n);
    end
    exp_q.delete();
    obs_q.delete();
    tick();
    rst = 1'b1;
    res_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp_after: got %0d results busy=%b want 0 busy=0", obs_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_backpressure();
    test_parity();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
